// File: rtl/debug_sequencer_pkg.sv
// Shared constants for the UART debug sequencer: command bytes, FSM encodings and the
// halt terminator word used to end an instruction-memory load.
package debug_sequencer_pkg;

    localparam int NBIT_DATA_LEN = 8;
    localparam int LEN_DATA      = 32;
    localparam int LEN_ADDR      = 10;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;
    localparam logic [7:0] CMD_RST  = 8'h04;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_STEP    = 3'd4;
    localparam logic [2:0] ST_SEND    = 3'd5;
    localparam logic [2:0] ST_WAIT_TX = 3'd6;

    localparam logic [LEN_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/debug_sequencer_if.sv
// Signal bundle between the debug sequencer (master) and the UART / core / instruction RAM.
// Ticks are single-cycle pulses; data_out is held from tx_start until the matching tx_done_tick.
interface debug_sequencer_if #(
    parameter int NBIT_DATA_LEN = 8,
    parameter int len_data      = 32,
    parameter int len_addr      = 10
);
    logic                     rx_done_tick;
    logic [NBIT_DATA_LEN-1:0] rx_data_in;
    logic                     tx_done_tick;
    logic                     halt;
    logic [len_data-1:0]      test_reg;
    logic                     tx_start;
    logic [NBIT_DATA_LEN-1:0] data_out;
    logic [len_addr-1:0]      addr_mem_inst;
    logic [len_data-1:0]      ins_to_mem;
    logic                     wr_ram_inst;
    logic                     ctrl_clk_mips;
    logic                     reset_mips;
    logic [2:0]               state_out;

    modport master (
        input  rx_done_tick, rx_data_in, tx_done_tick, halt, test_reg,
        output tx_start, data_out, addr_mem_inst, ins_to_mem, wr_ram_inst,
               ctrl_clk_mips, reset_mips, state_out
    );

    modport slave (
        output rx_done_tick, rx_data_in, tx_done_tick, halt, test_reg,
        input  tx_start, data_out, addr_mem_inst, ins_to_mem, wr_ram_inst,
               ctrl_clk_mips, reset_mips, state_out
    );
endinterface

// File: rtl/debug_sequencer_byte_serializer.sv
// Sends a 4-byte word MSB-first: each send pulse loads data_out and fires tx_start next cycle,
// each ack (tx_done seen by the owner) advances to the next byte.
module debug_sequencer_byte_serializer #(
    parameter int NBIT_DATA_LEN = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       send,
    input  logic                       ack,
    input  logic [4*NBIT_DATA_LEN-1:0] word,
    output logic                       tx_start,
    output logic [NBIT_DATA_LEN-1:0]   data_out,
    output logic                       last
);
    localparam int W = 4 * NBIT_DATA_LEN;

    logic [W-1:0] shreg;
    logic [W-1:0] src;
    logic [1:0]   idx;

    // The word is sampled when its first byte goes out, so the owner needs no load strobe.
    assign src  = (idx == 2'd0) ? word : shreg;
    assign last = (idx == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            idx      <= '0;
            tx_start <= 1'b0;
            data_out <= '0;
        end else begin
            tx_start <= 1'b0;
            if (send) begin
                data_out <= src[W-1 -: NBIT_DATA_LEN];
                shreg    <= {src[W-NBIT_DATA_LEN-1:0], {NBIT_DATA_LEN{1'b0}}};
                tx_start <= 1'b1;
            end
            if (ack) begin
                idx <= idx + 2'd1;
            end
        end
    end
endmodule

// File: rtl/debug_sequencer.sv
// UART command sequencer for the MIPS core: loads instruction RAM, resets, runs or steps the
// core, and reports the PC back over UART after each run or step.
module debug_sequencer
    import debug_sequencer_pkg::*;
#(
    parameter int NBIT_DATA_LEN = debug_sequencer_pkg::NBIT_DATA_LEN,
    parameter int len_data      = debug_sequencer_pkg::LEN_DATA,
    parameter int len_addr      = debug_sequencer_pkg::LEN_ADDR
) (
    input logic              clk,
    input logic              reset,
    debug_sequencer_if.master bus
);
    localparam logic [len_addr-1:0] ADDR_ONE = 1;

    logic [2:0]          state;
    logic [1:0]          byte_cnt;
    logic [len_addr-1:0] word_addr;
    logic [len_data-1:0] ins_buf;
    logic                reset_mips_q;
    logic                ser_send;
    logic                ser_ack;
    logic                ser_last;

    assign ser_send = (state == ST_SEND);
    assign ser_ack  = (state == ST_WAIT_TX) && bus.tx_done_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            byte_cnt     <= '0;
            word_addr    <= '0;
            ins_buf      <= '0;
            reset_mips_q <= 1'b0;
        end else begin
            reset_mips_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.rx_done_tick) begin
                        case (bus.rx_data_in)
                            CMD_LOAD: begin
                                state     <= ST_LOAD;
                                word_addr <= '0;
                                byte_cnt  <= '0;
                            end
                            CMD_RUN:  state <= ST_RUN;
                            CMD_STEP: state <= ST_STEP;
                            CMD_RST:  reset_mips_q <= 1'b1;
                            default:  ;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (bus.rx_done_tick) begin
                        ins_buf  <= {ins_buf[len_data-NBIT_DATA_LEN-1:0], bus.rx_data_in};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    // The terminator word is written too; a full RAM ends the load instead of wrapping.
                    word_addr <= word_addr + ADDR_ONE;
                    if (ins_buf == HALT_WORD || (&word_addr)) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                ST_RUN: begin
                    if (bus.halt) begin
                        state <= ST_SEND;
                    end
                end
                ST_STEP:  state <= ST_SEND;
                ST_SEND:  state <= ST_WAIT_TX;
                ST_WAIT_TX: begin
                    if (bus.tx_done_tick) begin
                        state <= ser_last ? ST_IDLE : ST_SEND;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    debug_sequencer_byte_serializer #(
        .NBIT_DATA_LEN(NBIT_DATA_LEN)
    ) u_serializer (
        .clk      (clk),
        .reset    (reset),
        .send     (ser_send),
        .ack      (ser_ack),
        .word     (bus.test_reg),
        .tx_start (bus.tx_start),
        .data_out (bus.data_out),
        .last     (ser_last)
    );

    // Clock enable follows halt combinationally so the core gets no extra cycle past halt.
    assign bus.ctrl_clk_mips = ((state == ST_RUN) && !bus.halt) || (state == ST_STEP);
    assign bus.wr_ram_inst   = (state == ST_WRITE);
    assign bus.addr_mem_inst = word_addr;
    assign bus.ins_to_mem    = ins_buf;
    assign bus.reset_mips    = reset_mips_q;
    assign bus.state_out     = state;
endmodule

// File: tb/tb_debug_sequencer.sv
// Directed bench for debug_sequencer: drivers push expected writes/bytes/resets into queues,
// a negedge monitor pops and compares whenever the DUT emits one.
module tb_debug_sequencer;
    import debug_sequencer_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    debug_sequencer_if bus ();

    debug_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run = 0;
    int fails     = 0;
    int ctrl_cnt  = 0;
    int tx_starts = 0;
    int tx_dones  = 0;

    logic [41:0] exp_wr_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [0:0]  exp_rst_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        tests_run++;
        fails++;
        $display("FAIL %s: got %0h expected no event", name, act);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (reset) begin
            if (bus.ctrl_clk_mips) ctrl_cnt++;
            if (bus.wr_ram_inst) begin
                if (exp_wr_q.size() == 0) unexpected("wr_unexpected", {bus.addr_mem_inst, bus.ins_to_mem});
                else check("wr", {bus.addr_mem_inst, bus.ins_to_mem}, exp_wr_q.pop_front());
            end
            if (bus.tx_start) begin
                check("tx_after_done", tx_starts, tx_dones);
                tx_starts++;
                if (exp_tx_q.size() == 0) unexpected("tx_unexpected", bus.data_out);
                else check("tx_byte", bus.data_out, exp_tx_q.pop_front());
            end
            if (bus.reset_mips) begin
                if (exp_rst_q.size() == 0) unexpected("rst_unexpected", bus.reset_mips);
                else check("reset_mips", bus.reset_mips, exp_rst_q.pop_front());
            end
        end
    end

    // UART transmitter model
    always begin
        @(negedge clk);
        if (reset && bus.tx_start) begin
            repeat (2) @(posedge clk);
            #1 bus.tx_done_tick = 1'b1;
            tx_dones++;
            @(posedge clk);
            #1 bus.tx_done_tick = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_data_in   = b;
        bus.rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_done_tick = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] w);
        send_rx(w[31:24]);
        send_rx(w[23:16]);
        send_rx(w[15:8]);
        send_rx(w[7:0]);
    endtask

    task automatic push_pc(input logic [31:0] w);
        exp_tx_q.push_back(w[31:24]);
        exp_tx_q.push_back(w[23:16]);
        exp_tx_q.push_back(w[15:8]);
        exp_tx_q.push_back(w[7:0]);
    endtask

    task automatic wait_state(input string name, input logic [2:0] st);
        int n;
        n = 0;
        while (bus.state_out != st && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, bus.state_out, st);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, bus.state_out, 3'd0);
        check({tag, "_tx_start"}, bus.tx_start, 1'b0);
        check({tag, "_data_out"}, bus.data_out, 8'h00);
        check({tag, "_addr"}, bus.addr_mem_inst, 10'd0);
        check({tag, "_ins"}, bus.ins_to_mem, 32'd0);
        check({tag, "_wr"}, bus.wr_ram_inst, 1'b0);
        check({tag, "_ctrl_clk"}, bus.ctrl_clk_mips, 1'b0);
        check({tag, "_reset_mips"}, bus.reset_mips, 1'b0);
    endtask

    initial begin
        int base;
        bus.rx_done_tick = 1'b0;
        bus.rx_data_in   = 8'h00;
        bus.tx_done_tick = 1'b0;
        bus.halt         = 1'b0;
        bus.test_reg     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset = 1'b1;

        // Load two words ending with the terminator
        exp_wr_q.push_back({10'd0, 32'h0000_0020});
        exp_wr_q.push_back({10'd1, 32'hFFFF_FFFF});
        send_rx(CMD_LOAD);
        load_word(32'h0000_0020);
        check("wr_one_cycle_after_tick", bus.wr_ram_inst, 1'b1);
        load_word(32'hFFFF_FFFF);
        wait_state("load_end_idle", ST_IDLE);
        check("load_wr_q_empty", exp_wr_q.size(), 0);

        // Single step
        bus.test_reg = 32'h0000_0004;
        push_pc(32'h0000_0004);
        base = ctrl_cnt;
        send_rx(CMD_STEP);
        wait_state("step_idle", ST_IDLE);
        check("step_core_cycles", ctrl_cnt - base, 1);
        check("step_tx_q_empty", exp_tx_q.size(), 0);

        // Run until halt after 37 core cycles
        bus.test_reg = 32'h1234_5678;
        push_pc(32'h1234_5678);
        base = ctrl_cnt;
        send_rx(CMD_RUN);
        for (int i = 0; i < 200; i++) begin
            if (ctrl_cnt - base >= 37) break;
            @(posedge clk);
            #1;
        end
        bus.halt = 1'b1;
        wait_state("run_idle", ST_IDLE);
        check("run_core_cycles", ctrl_cnt - base, 37);
        check("run_tx_q_empty", exp_tx_q.size(), 0);

        // Run with halt already set
        bus.test_reg = 32'hCAFE_0001;
        push_pc(32'hCAFE_0001);
        base = ctrl_cnt;
        send_rx(CMD_RUN);
        wait_state("run0_idle", ST_IDLE);
        check("run0_core_cycles", ctrl_cnt - base, 0);
        check("run0_tx_q_empty", exp_tx_q.size(), 0);
        bus.halt = 1'b0;

        // Core reset command, then non-command bytes in IDLE
        exp_rst_q.push_back(1'b1);
        base = ctrl_cnt;
        send_rx(CMD_RST);
        send_rx(8'h07);
        send_rx(8'h55);
        repeat (3) @(posedge clk);
        #1;
        check("junk_state_idle", bus.state_out, ST_IDLE);
        check("rst_q_empty", exp_rst_q.size(), 0);
        check("junk_no_core_cycles", ctrl_cnt - base, 0);

        // Bytes during RUN and WAIT_TX are dropped
        bus.test_reg = 32'h0A0B_0C0D;
        push_pc(32'h0A0B_0C0D);
        send_rx(CMD_RUN);
        send_rx(CMD_LOAD);
        send_rx(CMD_RST);
        send_rx(CMD_STEP);
        check("run_ignores_rx", bus.state_out, ST_RUN);
        bus.halt = 1'b1;
        wait_state("reach_wait_tx", ST_WAIT_TX);
        send_rx(CMD_RUN);
        wait_state("drop_idle", ST_IDLE);
        bus.halt = 1'b0;
        check("drop_tx_q_empty", exp_tx_q.size(), 0);

        // Fill the whole instruction RAM without a terminator
        for (int i = 0; i < 1024; i++) exp_wr_q.push_back({i[9:0], i + 32'd1});
        send_rx(CMD_LOAD);
        for (int i = 0; i < 1024; i++) load_word(i + 32'd1);
        wait_state("full_idle", ST_IDLE);
        load_word(32'h0000_0010);
        repeat (3) @(posedge clk);
        #1;
        check("full_wr_q_empty", exp_wr_q.size(), 0);
        check("full_after_idle", bus.state_out, ST_IDLE);

        // Reset in the middle of a load word
        send_rx(CMD_LOAD);
        send_rx(8'hAA);
        send_rx(8'hBB);
        reset = 1'b0;
        #1;
        check_all_zero("mid_load");
        @(posedge clk);
        #1 reset = 1'b1;

        // Reset in the middle of SEND
        bus.test_reg = 32'hDEAD_BEEF;
        push_pc(32'hDEAD_BEEF);
        send_rx(CMD_STEP);
        wait_state("send_wait_tx", ST_WAIT_TX);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_all_zero("mid_send");
        exp_tx_q.delete();
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;

        // Reset during RUN drops the core clock enable at once
        send_rx(CMD_RUN);
        check("run_ctrl_high", bus.ctrl_clk_mips, 1'b1);
        reset = 1'b0;
        #1;
        check("run_reset_ctrl", bus.ctrl_clk_mips, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Clean load after the resets
        exp_wr_q.push_back({10'd0, 32'h1122_3344});
        exp_wr_q.push_back({10'd1, 32'hFFFF_FFFF});
        send_rx(CMD_LOAD);
        load_word(32'h1122_3344);
        load_word(32'hFFFF_FFFF);
        wait_state("reload_idle", ST_IDLE);
        repeat (5) @(posedge clk);
        #1;
        check("reload_wr_q_empty", exp_wr_q.size(), 0);
        check("final_tx_q_empty", exp_tx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
